// File: rtl/button_event_decoder_pkg.sv
// Shared types and defaults for the button event decoder: FSM state encoding,
// event pulse bundle and default timing parameters.
package button_event_decoder_pkg;

    localparam int DEFAULT_LONG_TICKS   = 100;
    localparam int DEFAULT_DCLICK_TICKS = 25;
    localparam int DEFAULT_CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_e;

    // One bit per output pulse; registered as a group so they share timing.
    typedef struct packed {
        logic press;
        logic rel;
        logic long_press;
        logic single_click;
        logic double_click;
    } events_t;

endpackage

// File: rtl/button_event_decoder_tick_counter.sv
// Tick-enabled counter with synchronous clear and terminal-count compare;
// shared by the event decoder and the debounce timer.
module tick_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_at_term
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            // Saturate rather than wrap if a caller forgets to clear.
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long/single/double-click
// one-cycle pulses, all registered with one clock of latency.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
    parameter int DCLICK_TICKS = DEFAULT_DCLICK_TICKS,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_debounced,
    input  logic i_tick,
    output logic o_press,
    output logic o_release,
    output logic o_long_press,
    output logic o_single_click,
    output logic o_double_click,
    output logic o_held
);

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DCLICK_TERM = CNT_W'(DCLICK_TICKS - 1);

    state_e           r_state;
    events_t          r_evt;
    logic             r_held;

    logic             w_rise;
    logic             w_fall;
    logic             w_at_term;
    logic             w_timeout;
    logic             w_cnt_clear;
    logic             w_cnt_enable;
    logic [CNT_W-1:0] w_term;

    assign w_rise    =  i_debounced & ~r_held;
    assign w_fall    = ~i_debounced &  r_held;
    assign w_term    = (r_state == ST_PRESSED) ? LONG_TERM : DCLICK_TERM;
    assign w_timeout = i_tick & w_at_term;

    // Counter runs only in the two timed states and is cleared on any exit,
    // so each state entry starts counting from zero.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals (no latches).
        w_cnt_clear  = 1'b1;
        w_cnt_enable = 1'b0;
        case (r_state)
            ST_PRESSED: begin
                if (!(w_fall || w_timeout)) begin
                    w_cnt_clear  = 1'b0;
                    w_cnt_enable = i_tick;
                end
            end
            ST_WAIT_SECOND: begin
                if (!(w_rise || w_timeout)) begin
                    w_cnt_clear  = 1'b0;
                    w_cnt_enable = i_tick;
                end
            end
            default: begin
                w_cnt_clear  = 1'b1;
                w_cnt_enable = 1'b0;
            end
        endcase
    end

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .i_term    (w_term),
        .o_at_term (w_at_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_held  <= 1'b0;
            r_evt   <= '0;
        end else begin
            r_held <= i_debounced;
            r_evt  <= '0;
            // Edge checks precede timeouts so an edge wins a same-cycle collision.
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_evt.press <= 1'b1;
                        r_state     <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        r_evt.rel <= 1'b1;
                        r_state   <= ST_WAIT_SECOND;
                    end else if (w_timeout) begin
                        r_evt.long_press <= 1'b1;
                        r_state          <= ST_LONG_HELD;
                    end
                end
                ST_LONG_HELD: begin
                    if (w_fall) begin
                        r_evt.rel <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_WAIT_SECOND: begin
                    if (w_rise) begin
                        r_evt.press        <= 1'b1;
                        r_evt.double_click <= 1'b1;
                        r_state            <= ST_SECOND_PRESSED;
                    end else if (w_timeout) begin
                        r_evt.single_click <= 1'b1;
                        r_state            <= ST_IDLE;
                    end
                end
                ST_SECOND_PRESSED: begin
                    if (w_fall) begin
                        r_evt.rel <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_press        = r_evt.press;
    assign o_release      = r_evt.rel;
    assign o_long_press   = r_evt.long_press;
    assign o_single_click = r_evt.single_click;
    assign o_double_click = r_evt.double_click;
    assign o_held         = r_held;

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_TICKS, default 100: tick count while held that declares a long press; legal range 1..2^CNT_W-1.
REQ-002 Parameter DCLICK_TICKS, default 25: tick count after a short release during which a second press counts as a double click; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 8: tick counter width.
REQ-004 clk  input  1  single clock; all logic rises on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 debounced  input  1  clean button level from the debouncer, synchronous to clk.
REQ-007 tick  input  1  one-cycle timebase enable; the internal counter advances only on cycles with tick=1.
REQ-008 press  output  1  one-cycle pulse on each 0->1 of debounced.
REQ-009 release  output  1  one-cycle pulse on each 1->0 of debounced.
REQ-010 long_press  output  1  one-cycle pulse when a hold reaches LONG_TICKS.
REQ-011 single_click  output  1  one-cycle pulse when a short click is not followed by a second press within DCLICK_TICKS.
REQ-012 double_click  output  1  one-cycle pulse on the second press of a double click.
REQ-013 held  output  1  registered copy of debounced.

Function
REQ-014 All outputs are registered; latency is 1 clock: an edge of debounced sampled at clock edge k drives its pulse high from edge k to edge k+1.
REQ-015 held is the sampled debounced level; edges are detected by comparing debounced with held.
REQ-016 States: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED; the tick counter clears on every state transition.
REQ-017 IDLE: rising edge -> press, go to PRESSED.
REQ-018 PRESSED: counter increments on tick; on a tick with counter = LONG_TICKS-1 -> long_press, go to LONG_HELD; on a falling edge -> release, go to WAIT_SECOND.
REQ-019 LONG_HELD: falling edge -> release, go to IDLE; no click event is generated.
REQ-020 WAIT_SECOND: counter increments on tick; on a tick with counter = DCLICK_TICKS-1 -> single_click, go to IDLE; on a rising edge -> press and double_click in the same cycle, go to SECOND_PRESSED.
REQ-021 SECOND_PRESSED: no long-press detection; falling edge -> release, go to IDLE.
REQ-022 When an edge and a terminal tick occur in the same cycle, the edge wins: the edge event fires, the timeout event is suppressed, and the edge transition is taken.
REQ-023 The counter never wraps; it is cleared on state exit before reaching 2^CNT_W-1.
REQ-024 At most one of long_press, single_click, double_click is high in any cycle.
REQ-025 Unused state encodings return to IDLE on the next clock with all pulses low.

Reset
REQ-026 While rst_n=0: state=IDLE, counter=0, held=0, and all pulse outputs are 0, taking effect immediately.
REQ-027 If debounced=1 at reset release, press asserts on the first active clock and the FSM enters PRESSED.
REQ-028 Reset asserted mid-operation discards any pending click, double-click or long-press event.

Structure
REQ-029 A shared package holds the state encoding (3-bit enum) and the default values for LONG_TICKS and DCLICK_TICKS.
REQ-030 The tick counter is a sub-module, tick_counter (clear, enable, terminal-count compare), reusable by the debounce timer.

Verification
Bench setup: LONG_TICKS=4, DCLICK_TICKS=3, tick=1 every cycle.
REQ-031 Single click: debounced high for 2 cycles, then low -> press, then release, then single_click exactly 3 cycles after release; no double_click.
REQ-032 Double click: high 2 cycles, low 1 cycle, high 2 cycles -> press, release, press+double_click in the same cycle, then release; no single_click.
REQ-033 Long press: high for 10 cycles -> long_press exactly 4 cycles after press; on release -> release only, no single_click.
REQ-034 Collision: second rising edge in the same cycle as the 3rd tick in WAIT_SECOND -> double_click; single_click never fires.
REQ-035 Reset mid-hold: drop rst_n at hold cycle 2 with debounced still high -> outputs 0 immediately; after release, press fires on the first clock, and long_press fires 4 ticks later.
REQ-036 Sparse tick (1 in 4 cycles), held 20 cycles -> long_press on the 4th tick after press, never earlier.
